// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state types and the
// byte-strobe merge used by register write paths.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axils_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers with byte
// strobes, independent read/write FSMs and SLVERR on out-of-range indices.
module axils_regfile
  import axil_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                     ARESETN,
  input  logic                     ACLK,
  input  logic [31:0]              AXI_AWADDR,
  input  logic [3:0]               AXI_AWCACHE,
  input  logic [2:0]               AXI_AWPROT,
  input  logic                     AXI_AWVALID,
  output logic                     AXI_AWREADY,
  input  logic [31:0]              AXI_WDATA,
  input  logic [3:0]               AXI_WSTRB,
  input  logic                     AXI_WVALID,
  output logic                     AXI_WREADY,
  output logic                     AXI_BVALID,
  input  logic                     AXI_BREADY,
  output logic [1:0]               AXI_BRESP,
  input  logic [31:0]              AXI_ARADDR,
  input  logic [3:0]               AXI_ARCACHE,
  input  logic [2:0]               AXI_ARPROT,
  input  logic                     AXI_ARVALID,
  output logic                     AXI_ARREADY,
  output logic [31:0]              AXI_RDATA,
  output logic [1:0]               AXI_RRESP,
  output logic                     AXI_RVALID,
  input  logic                     AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   REG_OUT,
  output logic [NUM_REGS-1:0]      REG_WE
);

  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  function automatic logic in_range(input logic [29:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  logic [31:0] regs [NUM_REGS];

  wr_state_t   w_state;
  rd_state_t   r_state;
  logic        aw_done, w_done;
  logic [29:0] aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        aw_hs, w_hs, ar_hs, commit, cmt_inr, ar_inr;
  logic [29:0] cmt_idx, ar_idx;
  logic [31:0] cmt_data;
  logic [3:0]  cmt_strb;
  logic [IW-1:0] cmt_sel, ar_sel;

  logic unused_inputs;
  assign unused_inputs = ^{AXI_AWCACHE, AXI_AWPROT, AXI_ARCACHE, AXI_ARPROT,
                           AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  // A handshake completing this cycle is used directly so AW/W may arrive
  // in either order or together.
  always_comb begin
    aw_hs    = AXI_AWVALID && AXI_AWREADY;
    w_hs     = AXI_WVALID && AXI_WREADY;
    ar_hs    = AXI_ARVALID && AXI_ARREADY;
    cmt_idx  = aw_hs ? AXI_AWADDR[31:2] : aw_idx_q;
    cmt_data = w_hs ? AXI_WDATA : wdata_q;
    cmt_strb = w_hs ? AXI_WSTRB : wstrb_q;
    commit   = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
    cmt_inr  = in_range(cmt_idx);
    cmt_sel  = cmt_idx[IW-1:0];
    ar_idx   = AXI_ARADDR[31:2];
    ar_inr   = in_range(ar_idx);
    ar_sel   = ar_idx[IW-1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      REG_WE <= '0;
    end else begin
      REG_WE <= '0;
      if (commit && cmt_inr) begin
        regs[cmt_sel]   <= byte_merge(regs[cmt_sel], cmt_data, cmt_strb);
        REG_WE[cmt_sel] <= 1'b1;
      end
    end
  end

  always_comb begin
    REG_OUT = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) REG_OUT[32*k +: 32] = regs[k];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state     <= W_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      AXI_AWREADY <= 1'b0;
      AXI_WREADY  <= 1'b0;
      AXI_BVALID  <= 1'b0;
      AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) aw_idx_q <= AXI_AWADDR[31:2];
          if (w_hs) begin
            wdata_q <= AXI_WDATA;
            wstrb_q <= AXI_WSTRB;
          end
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done || w_hs;
          if (commit) begin
            AXI_AWREADY <= 1'b0;
            AXI_WREADY  <= 1'b0;
            AXI_BVALID  <= 1'b1;
            AXI_BRESP   <= cmt_inr ? RESP_OKAY : RESP_SLVERR;
            w_state     <= W_RESP;
          end else begin
            AXI_AWREADY <= !(aw_done || aw_hs);
            AXI_WREADY  <= !(w_done || w_hs);
          end
        end
        W_RESP: begin
          if (AXI_BREADY) begin
            AXI_BVALID  <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            AXI_AWREADY <= 1'b1;
            AXI_WREADY  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
      endcase
    end
  end

  // regs is sampled before the same-edge commit lands, giving pre-write data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= R_IDLE;
      AXI_ARREADY <= 1'b0;
      AXI_RVALID  <= 1'b0;
      AXI_RDATA   <= '0;
      AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            AXI_RDATA   <= ar_inr ? regs[ar_sel] : '0;
            AXI_RRESP   <= ar_inr ? RESP_OKAY : RESP_SLVERR;
            AXI_RVALID  <= 1'b1;
            AXI_ARREADY <= 1'b0;
            r_state     <= R_DATA;
          end else begin
            AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (AXI_RREADY) begin
            AXI_RVALID  <= 1'b0;
            AXI_ARREADY <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axils_regfile.sv
// Self-checking bench for axils_regfile: directed scenarios then randomized
// traffic, checked against an array model of the register contents.
`timescale 1ns/1ps
module tb_axils_regfile;

  localparam int NR = 16;

  logic          ARESETN, ACLK;
  logic [31:0]   AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic [3:0]    AXI_AWCACHE, AXI_ARCACHE, AXI_WSTRB;
  logic [2:0]    AXI_AWPROT, AXI_ARPROT;
  logic          AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic          AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
  logic          AXI_RVALID, AXI_RREADY;
  logic [1:0]    AXI_BRESP, AXI_RRESP;
  logic [32*NR-1:0] REG_OUT;
  logic [NR-1:0] REG_WE;

  axils_regfile #(.NUM_REGS(NR)) dut (
    .ARESETN(ARESETN), .ACLK(ACLK),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWCACHE(AXI_AWCACHE), .AXI_AWPROT(AXI_AWPROT),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY), .AXI_BRESP(AXI_BRESP),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARCACHE(AXI_ARCACHE), .AXI_ARPROT(AXI_ARPROT),
    .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .REG_OUT(REG_OUT), .REG_WE(REG_WE)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [NR];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] mask;
    mask = (strb[0] ? 32'h0000_00FF : 32'h0) | (strb[1] ? 32'h0000_FF00 : 32'h0) |
           (strb[2] ? 32'h00FF_0000 : 32'h0) | (strb[3] ? 32'hFF00_0000 : 32'h0);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic bit addr_ok(input logic [31:0] addr);
    return (addr / 4) < NR;
  endfunction

  task automatic chk_regs(input string tag);
    for (int k = 0; k < NR; k++) chk($sformatf("%s_reg%0d", tag, k), REG_OUT[32*k +: 32], mdl[k]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_at, input int w_at,
                          input int b_delay);
    int c;
    bit awd, wd, awh, wh, inr;
    int unsigned idx;
    logic [NR-1:0] exp_we;
    c = 0; awd = 0; wd = 0;
    idx = addr / 4;
    inr = addr_ok(addr);
    while (!(awd && wd) && c < 40) begin
      @(negedge ACLK);
      AXI_AWADDR  = addr;
      AXI_WDATA   = data;
      AXI_WSTRB   = strb;
      AXI_AWVALID = !awd && (c >= aw_at);
      AXI_WVALID  = !wd && (c >= w_at);
      awh = AXI_AWVALID && AXI_AWREADY;
      wh  = AXI_WVALID && AXI_WREADY;
      @(posedge ACLK);
      awd = awd | awh;
      wd  = wd | wh;
      c++;
    end
    chk("wr_handshake", {awd, wd}, 2'b11);
    if (awd && wd && inr) mdl[idx] = model_merge(mdl[idx], data, strb);
    exp_we = inr ? (NR'(1) << idx) : '0;
    @(negedge ACLK);
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    chk("wr_bvalid", AXI_BVALID, 1'b1);
    chk("wr_bresp", AXI_BRESP, inr ? 2'b00 : 2'b10);
    chk("wr_we_pulse", REG_WE, exp_we);
    chk_regs("wr");
    for (int i = 0; i < b_delay; i++) begin
      @(negedge ACLK);
      chk("wr_bhold", {AXI_BVALID, AXI_AWREADY, AXI_WREADY}, 3'b100);
      chk("wr_we_once", REG_WE, '0);
    end
    AXI_BREADY = 1'b1;
    @(negedge ACLK);
    AXI_BREADY = 1'b0;
    chk("wr_bdone", {AXI_BVALID, AXI_AWREADY, AXI_WREADY}, 3'b011);
    chk("wr_we_after", REG_WE, '0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_delay);
    int c;
    bit inr;
    logic [31:0] exp_d;
    c = 0;
    inr = addr_ok(addr);
    @(negedge ACLK);
    AXI_ARADDR  = addr;
    AXI_ARVALID = 1'b1;
    while (!AXI_ARREADY && c < 20) begin
      @(negedge ACLK);
      c++;
    end
    chk("rd_arready", AXI_ARREADY, 1'b1);
    exp_d = inr ? mdl[addr / 4] : 32'h0;
    @(negedge ACLK);
    AXI_ARVALID = 1'b0;
    chk("rd_valid", {AXI_RVALID, AXI_ARREADY}, 2'b10);
    chk("rd_data", AXI_RDATA, exp_d);
    chk("rd_resp", AXI_RRESP, inr ? 2'b00 : 2'b10);
    for (int i = 0; i < r_delay; i++) begin
      @(negedge ACLK);
      chk("rd_hold", {AXI_RVALID, AXI_RRESP, AXI_RDATA}, {1'b1, inr ? 2'b00 : 2'b10, exp_d});
    end
    AXI_RREADY = 1'b1;
    @(negedge ACLK);
    AXI_RREADY = 1'b0;
    chk("rd_done", {AXI_RVALID, AXI_ARREADY}, 2'b01);
  endtask

  initial begin
    logic [31:0] exp_old, a, d;
    ARESETN = 1'b0;
    AXI_AWADDR = '0; AXI_AWCACHE = '0; AXI_AWPROT = '0; AXI_AWVALID = 1'b0;
    AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_ARADDR = '0; AXI_ARCACHE = '0; AXI_ARPROT = '0; AXI_ARVALID = 1'b0;
    AXI_RREADY = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = '0;

    // Reset state and first-edge readiness
    repeat (3) @(negedge ACLK);
    chk("rst_ready", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b000);
    chk("rst_valid", {AXI_BVALID, AXI_RVALID, AXI_BRESP, AXI_RRESP}, 6'b0);
    chk("rst_rdata", AXI_RDATA, 32'h0);
    chk("rst_we", REG_WE, '0);
    chk_regs("rst");
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_release_ready", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b111);

    // Read handshake on the same edge as a write commit to reg 2
    @(negedge ACLK);
    AXI_AWADDR = 32'h8; AXI_WDATA = 32'hA5A5A5A5; AXI_WSTRB = 4'hF;
    AXI_ARADDR = 32'h8;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_ARVALID = 1'b1;
    chk("same_edge_ready", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b111);
    exp_old = mdl[2];
    @(negedge ACLK);
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0;
    mdl[2] = 32'hA5A5A5A5;
    chk("same_edge_rdata", AXI_RDATA, exp_old);
    chk("same_edge_valids", {AXI_BVALID, AXI_RVALID}, 2'b11);
    chk("same_edge_reg2", REG_OUT[64 +: 32], mdl[2]);
    AXI_BREADY = 1'b1; AXI_RREADY = 1'b1;
    @(negedge ACLK);
    AXI_BREADY = 1'b0; AXI_RREADY = 1'b0;
    chk("same_edge_done", {AXI_BVALID, AXI_RVALID}, 2'b00);
    do_read(32'h8, 0);

    // Full write, AW one cycle ahead of W, then read back
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 1, 0);
    do_read(32'h4, 2);

    // Byte-strobe merge
    do_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h8, 32'h12345678, 4'b0101, 1, 0, 0);
    do_read(32'h8, 0);
    chk("strobe_merge_model", mdl[2], 32'hFF34FF78);

    // W leads AW by 3 cycles, BREADY held off for 4 cycles
    do_write(32'hC, 32'h0BADF00D, 4'hF, 3, 0, 4);
    do_write(32'h10, 32'h55AA55AA, 4'h0, 0, 0, 0);

    // Out-of-range accesses
    do_write(32'h40, 32'hCAFEBABE, 4'hF, 0, 0, 1);
    do_read(32'h40, 1);

    // Reset while a write response is pending
    do_write(32'hC, 32'h0, 4'hF, 0, 0, 0);
    @(negedge ACLK);
    AXI_AWADDR = 32'hC; AXI_WDATA = 32'h11; AXI_WSTRB = 4'hF;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1;
    @(negedge ACLK);
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    chk("pre_reset_bvalid", AXI_BVALID, 1'b1);
    chk("pre_reset_reg3", REG_OUT[96 +: 32], 32'h11);
    #2 ARESETN = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    chk("mid_reset_outputs", {AXI_BVALID, AXI_RVALID, AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 5'b0);
    chk("mid_reset_reg3", REG_OUT[96 +: 32], 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("release_ready_low", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b000);
    @(negedge ACLK);
    chk("release_ready_high", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b111);
    chk_regs("post_reset");

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      d = $urandom;
      AXI_AWCACHE = 4'($urandom); AXI_AWPROT = 3'($urandom);
      AXI_ARCACHE = 4'($urandom); AXI_ARPROT = 3'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end
    chk_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
